// File: rtl/fetch_unit.sv
// Instruction fetch front end: issues one word-aligned memory request at a time
// and buffers responses in a small FIFO that feeds the decoder.
module fetch_unit #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          QUEUE_DEPTH = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        inst_valid_o,
  output logic [31:0] inst_o,
  output logic [31:0] inst_pc_o,
  input  logic        inst_ready_i
);

  localparam int PW = $clog2(QUEUE_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH = CW'(QUEUE_DEPTH);

  typedef enum logic [1:0] {IDLE, REQ, RESP, DRAIN} state_t;

  state_t        state, state_next;
  logic [31:0]   pc, req_pc;
  logic [31:0]   q_inst [QUEUE_DEPTH];
  logic [31:0]   q_pc   [QUEUE_DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count, count_pushed;
  logic          push, pop, take_gnt;

  assign inst_valid_o = (count != '0);
  assign inst_o       = inst_valid_o ? q_inst[rd_ptr] : 32'h0;
  assign inst_pc_o    = inst_valid_o ? q_pc[rd_ptr]   : 32'h0;
  assign imem_req_o   = (state == REQ);
  assign imem_addr_o  = pc;
  assign pop          = inst_valid_o & inst_ready_i;

  always_comb begin
    state_next   = state;
    push         = 1'b0;
    take_gnt     = 1'b0;
    count_pushed = count + CW'(1) - CW'(pop);
    case (state)
      IDLE:  if (count < DEPTH) state_next = REQ;
      REQ:   if (imem_gnt_i) begin
               take_gnt   = 1'b1;
               state_next = RESP;
             end
      RESP:  if (imem_rvalid_i) begin
               push       = 1'b1;
               state_next = (count_pushed < DEPTH) ? REQ : IDLE;
             end
      DRAIN: if (imem_rvalid_i) state_next = REQ;
      default: state_next = IDLE;
    endcase
    // A redirect flushes everything; an accepted-but-unanswered request must still be drained.
    if (redirect_i) begin
      push = 1'b0;
      case (state)
        REQ:     state_next = imem_gnt_i    ? DRAIN : REQ;
        RESP:    state_next = imem_rvalid_i ? REQ   : DRAIN;
        default: state_next = REQ;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state  <= IDLE;
      pc     <= RESET_PC;
      req_pc <= 32'h0;
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else begin
      state <= state_next;
      if (take_gnt) req_pc <= pc;
      if (redirect_i) begin
        pc     <= {redirect_pc_i[31:2], 2'b00};
        count  <= '0;
        rd_ptr <= '0;
        wr_ptr <= '0;
      end else begin
        if (take_gnt) pc <= pc + 32'd4;
        if (push) wr_ptr <= wr_ptr + PW'(1);
        if (pop)  rd_ptr <= rd_ptr + PW'(1);
        count <= count + CW'(push) - CW'(pop);
      end
    end
  end

  // Storage needs no reset: entries are only visible while count says they are live.
  always_ff @(posedge clk_i) begin
    if (push && !redirect_i && !rst_i) begin
      q_inst[wr_ptr] <= imem_rdata_i;
      q_pc[wr_ptr]   <= req_pc;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a scoreboard queue of expected decoder
// handshakes checked by an independent monitor, plus point checks on the memory side.
module tb_fetch_unit;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        inst_valid_o;
  logic [31:0] inst_o;
  logic [31:0] inst_pc_o;
  logic        inst_ready_i;

  always #5 clk_i = ~clk_i;

  fetch_unit #(.RESET_PC(32'h0000_0000), .QUEUE_DEPTH(2)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o),
    .imem_gnt_i(imem_gnt_i), .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i),
    .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
    .inst_valid_o(inst_valid_o), .inst_o(inst_o), .inst_pc_o(inst_pc_o),
    .inst_ready_i(inst_ready_i)
  );

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
  } entry_t;

  entry_t exp_q[$];
  entry_t mon_e;
  int     total = 0;
  int     bad   = 0;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk_i);
    #1;
  endtask

  task automatic apply_reset();
    rst_i         = 1'b1;
    imem_gnt_i    = 1'b0;
    imem_rvalid_i = 1'b0;
    imem_rdata_i  = 32'h0;
    redirect_i    = 1'b0;
    redirect_pc_i = 32'h0;
    repeat (2) cycle();
    rst_i = 1'b0;
    exp_q.delete();
  endtask

  // Memory grants immediately and answers one cycle after the grant.
  task automatic fetch_one(input logic [31:0] addr, input logic [31:0] data);
    check_output("req_high", 32'(imem_req_o), 32'd1);
    check_output("req_addr", imem_addr_o, addr);
    imem_gnt_i = 1'b1;
    cycle();
    imem_gnt_i = 1'b0;
    check_output("resp_no_req", 32'(imem_req_o), 32'd0);
    imem_rvalid_i = 1'b1;
    imem_rdata_i  = data;
    exp_q.push_back('{inst: data, pc: addr});
    cycle();
    imem_rvalid_i = 1'b0;
    imem_rdata_i  = 32'h0;
    check_output("valid_latency", 32'(inst_valid_o), 32'd1);
  endtask

  // Decoder-side monitor; a handshake during redirect is a discarded pop.
  always @(negedge clk_i) begin
    if (!rst_i && !redirect_i && inst_valid_o && inst_ready_i) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("[TB] FAIL unexpected_pop: got pc %h inst %h, required no entry", inst_pc_o, inst_o);
      end else begin
        mon_e = exp_q.pop_front();
        check_output("pop_pc", inst_pc_o, mon_e.pc);
        check_output("pop_inst", inst_o, mon_e.inst);
      end
    end
  end

  initial begin
    inst_ready_i = 1'b1;
    apply_reset();
    check_output("rst_req", 32'(imem_req_o), 32'd0);
    check_output("rst_addr", imem_addr_o, 32'h0);
    check_output("rst_valid", 32'(inst_valid_o), 32'd0);
    check_output("rst_inst", inst_o, 32'h0);
    check_output("rst_inst_pc", inst_pc_o, 32'h0);

    // streaming with an always-ready consumer
    cycle();
    check_output("first_req", 32'(imem_req_o), 32'd1);
    fetch_one(32'h0, 32'h0000_0013);
    fetch_one(32'h4, 32'h0010_0093);
    fetch_one(32'h8, 32'h0020_0113);
    cycle();
    check_output("s1_drained", exp_q.size(), 32'd0);

    // back-pressure fills the queue and parks the FSM
    inst_ready_i = 1'b0;
    apply_reset();
    cycle();
    fetch_one(32'h0, 32'hAAAA_0001);
    fetch_one(32'h4, 32'hAAAA_0002);
    repeat (3) begin
      cycle();
      check_output("full_no_req", 32'(imem_req_o), 32'd0);
    end
    check_output("full_valid", 32'(inst_valid_o), 32'd1);
    check_output("full_head_pc", inst_pc_o, 32'h0);
    check_output("full_head_inst", inst_o, 32'hAAAA_0001);
    inst_ready_i = 1'b1;
    cycle();
    check_output("resume_wait", 32'(imem_req_o), 32'd0);
    cycle();
    fetch_one(32'h8, 32'hAAAA_0003);
    cycle();
    check_output("s2_drained", exp_q.size(), 32'd0);

    // redirect during RESP, late word must be dropped
    apply_reset();
    cycle();
    imem_gnt_i = 1'b1;
    cycle();
    imem_gnt_i    = 1'b0;
    redirect_i    = 1'b1;
    redirect_pc_i = 32'h100;
    cycle();
    redirect_i = 1'b0;
    check_output("drain_no_req", 32'(imem_req_o), 32'd0);
    imem_rvalid_i = 1'b1;
    imem_rdata_i  = 32'hDEAD_BEEF;
    cycle();
    imem_rvalid_i = 1'b0;
    check_output("drain_no_valid", 32'(inst_valid_o), 32'd0);
    fetch_one(32'h100, 32'hBBBB_0001);
    cycle();
    // redirect together with a grant
    imem_gnt_i    = 1'b1;
    redirect_i    = 1'b1;
    redirect_pc_i = 32'h300;
    cycle();
    imem_gnt_i = 1'b0;
    redirect_i = 1'b0;
    check_output("gnt_redir_drain", 32'(imem_req_o), 32'd0);
    imem_rvalid_i = 1'b1;
    imem_rdata_i  = 32'hBAD0_0300;
    cycle();
    imem_rvalid_i = 1'b0;
    check_output("gnt_redir_no_valid", 32'(inst_valid_o), 32'd0);
    fetch_one(32'h300, 32'hBBBB_0002);
    cycle();
    check_output("s3_drained", exp_q.size(), 32'd0);

    // redirect with rvalid and pop in the same cycle, unaligned target
    inst_ready_i = 1'b0;
    apply_reset();
    cycle();
    fetch_one(32'h0, 32'hCCCC_0001);
    imem_gnt_i = 1'b1;
    cycle();
    imem_gnt_i    = 1'b0;
    imem_rvalid_i = 1'b1;
    imem_rdata_i  = 32'hCCCC_0002;
    inst_ready_i  = 1'b1;
    redirect_i    = 1'b1;
    redirect_pc_i = 32'h203;
    exp_q.delete();
    cycle();
    imem_rvalid_i = 1'b0;
    redirect_i    = 1'b0;
    check_output("flush_valid", 32'(inst_valid_o), 32'd0);
    check_output("flush_inst", inst_o, 32'h0);
    check_output("flush_inst_pc", inst_pc_o, 32'h0);
    fetch_one(32'h200, 32'hCCCC_0003);
    cycle();
    redirect_i    = 1'b1;
    redirect_pc_i = 32'h40;
    cycle();
    redirect_i = 1'b0;
    check_output("redir_latency_req", 32'(imem_req_o), 32'd1);
    check_output("redir_latency_addr", imem_addr_o, 32'h40);
    repeat (2) cycle();
    check_output("addr_stable", imem_addr_o, 32'h40);
    fetch_one(32'h40, 32'hCCCC_0004);
    cycle();

    // pc wraps at the top of the address space
    redirect_i    = 1'b1;
    redirect_pc_i = 32'hFFFF_FFFC;
    cycle();
    redirect_i = 1'b0;
    fetch_one(32'hFFFF_FFFC, 32'hDDDD_0001);
    fetch_one(32'h0, 32'hDDDD_0002);

    // reset while a response is outstanding
    imem_gnt_i = 1'b1;
    cycle();
    imem_gnt_i    = 1'b0;
    rst_i         = 1'b1;
    imem_rvalid_i = 1'b1;
    imem_rdata_i  = 32'hBAD0_0004;
    cycle();
    rst_i = 1'b0;
    exp_q.delete();
    check_output("rst_resp_valid", 32'(inst_valid_o), 32'd0);
    check_output("rst_resp_req", 32'(imem_req_o), 32'd0);
    cycle();
    imem_rvalid_i = 1'b0;
    check_output("rst_late_rvalid", 32'(inst_valid_o), 32'd0);
    fetch_one(32'h0, 32'hEEEE_0001);
    cycle();
    check_output("final_drained", exp_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameters SHALL be: RESET_PC, 32'h0000_0000, first fetch address; QUEUE_DEPTH, 2, instruction queue entries (legal values: 2 or 4).
REQ-002 clk_i  in  1  single clock; all state updates SHALL occur on its rising edge.
REQ-003 rst_i  in  1  reset; synchronous and active-high.
REQ-004 imem_req_o  out  1  instruction memory request.
REQ-005 imem_addr_o  out  32  request address, word-aligned.
REQ-006 imem_gnt_i  in  1  request accepted this cycle.
REQ-007 imem_rvalid_i  in  1  response data valid.
REQ-008 imem_rdata_i  in  32  response instruction word.
REQ-009 redirect_i  in  1  branch/jal/jalr/syscall redirect from execute.
REQ-010 redirect_pc_i  in  32  redirect target.
REQ-011 inst_valid_o  out  1  queue head valid, feeding the decoder.
REQ-012 inst_o  out  32  queue head instruction, driving the decoder's instruction_i.
REQ-013 inst_pc_o  out  32  PC of the queue head.
REQ-014 inst_ready_i  in  1  consumer accepts the head this cycle.

Function
REQ-015 The fetch FSM SHALL have the states IDLE, REQ, RESP and DRAIN; at most one memory request SHALL be outstanding at any time.
REQ-016 In IDLE, imem_req_o SHALL be 0; the FSM SHALL move to REQ when count < QUEUE_DEPTH.
REQ-017 In REQ, imem_req_o SHALL be 1 and imem_addr_o SHALL equal pc; on imem_gnt_i the FSM SHALL latch req_pc=pc, set pc=pc+4 (modulo 2^32, so 32'hFFFF_FFFC wraps to 0), and move to RESP.
REQ-018 In RESP, imem_req_o SHALL be 0; on imem_rvalid_i the block SHALL push {imem_rdata_i, req_pc} into the queue.
REQ-019 On leaving RESP, the FSM SHALL go to REQ if post-push count < QUEUE_DEPTH, and to IDLE otherwise.
REQ-020 imem_gnt_i and imem_rvalid_i SHALL be ignored in states where they are not expected.
REQ-021 The queue SHALL be a FIFO: inst_valid_o = (count != 0); inst_o and inst_pc_o come from the head entry; inst_o and inst_pc_o SHALL be 0 when the queue is empty.
REQ-022 A pop SHALL occur when inst_valid_o and inst_ready_i are both 1.
REQ-023 A push and a pop in the same cycle SHALL leave count unchanged and preserve order.
REQ-024 A push to a full queue SHALL be impossible by construction, because REQ is entered only with a free slot.
REQ-025 Redirect SHALL take priority over every other event; in the cycle redirect_i=1 the block SHALL:
 - flush the queue (count=0), with any same-cycle pop or push discarded;
 - set pc = {redirect_pc_i[31:2], 2'b00};
 - go to REQ from IDLE, REQ (without gnt) or DRAIN;
 - go to DRAIN from RESP without rvalid, or from REQ with gnt in the same cycle;
 - go to REQ from RESP with rvalid in the same cycle (response discarded).
REQ-026 In DRAIN, imem_req_o SHALL be 0; the next imem_rvalid_i SHALL be discarded, after which the FSM moves to REQ.
REQ-027 In REQ without gnt, imem_addr_o SHALL stay stable except when changed by a redirect.
REQ-028 Latency: a gnt in cycle N and rvalid in cycle N+1 SHALL give inst_valid_o=1 in cycle N+2; the redirect-to-request latency SHALL be 1 cycle (no discard pending).

Reset
REQ-029 While rst_i=1 at a clock edge, the block SHALL set state=IDLE, pc=RESET_PC, count=0, and clear the queue pointers.
REQ-030 Outputs after that reset edge SHALL be: imem_req_o=0, imem_addr_o=RESET_PC, inst_valid_o=0, inst_o=0, inst_pc_o=0.
REQ-031 Reset during RESP or DRAIN SHALL abandon the outstanding response; any imem_rvalid_i arriving after reset while in IDLE SHALL be ignored.
REQ-032 The first imem_req_o=1 SHALL occur in the second cycle after rst_i deasserts.

Verification
REQ-033 Reset release, memory always granting, rvalid one cycle after gnt, inst_ready_i=1 -> consecutive addresses 0x0, 0x4, 0x8 with matching inst_pc_o and in-order inst_o.
REQ-034 inst_ready_i=0 held with QUEUE_DEPTH=2 -> exactly 2 entries (pc 0x0, 0x4), FSM in IDLE, no third request; ready=1 -> requests resume at 0x8.
REQ-035 Redirect to 0x100 while in RESP, then rvalid with 0xDEADBEEF -> word discarded, next request addr 0x100, inst_valid_o stays 0 until the 0x100 response.
REQ-036 redirect_i with redirect_pc_i=0x203 in the same cycle as rvalid and a pop -> queue empty, next request addr 0x200.
REQ-037 pc=0xFFFF_FFFC granted -> next request addr 0x0000_0000.
REQ-038 rst_i asserted in RESP, rvalid arrives during reset and one cycle after -> no push, inst_valid_o=0, fetch restarts at RESET_PC.
